// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU sequencer: opcodes, data width,
// FSM state encoding and the captured-response record.
package alu_pkg;

    localparam int ALU_W = 4;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_GT  = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_SHR = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } seq_state_e;

    // Everything the response channel carries besides valid.
    typedef struct packed {
        logic [ALU_W-1:0] result;
        logic             carry;
        logic             overflow;
        logic             zero;
    } alu_rsp_t;

    // A load reports its immediate with carry/overflow cleared and zero
    // reflecting the loaded value.
    function automatic alu_rsp_t load_rsp(input logic [ALU_W-1:0] imm);
        alu_rsp_t r;
        r.result   = imm;
        r.carry    = 1'b0;
        r.overflow = 1'b0;
        r.zero     = (imm == '0);
        return r;
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// NREGS x ALU_W register file: two combinational read ports, one
// synchronous write port, synchronous clear on reset.
module alu_seq_regfile
    import alu_pkg::*;
#(
    parameter int NREGS = 4,
    parameter int IDX_W = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [ALU_W-1:0] wdata_i,
    input  logic [IDX_W-1:0] raddr_a_i,
    input  logic [IDX_W-1:0] raddr_b_i,
    output logic [ALU_W-1:0] rdata_a_o,
    output logic [ALU_W-1:0] rdata_b_o
);

    logic [NREGS-1:0][ALU_W-1:0] rf_q;

    // Single write port; reset clears every entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_q <= '0;
        end else if (we_i) begin
            rf_q[waddr_i] <= wdata_i;
        end
    end

    // NREGS is a power of two, so every index is in range.
    assign rdata_a_o = rf_q[raddr_a_i];
    assign rdata_b_o = rf_q[raddr_b_i];

endmodule

// File: rtl/alu_4bit_sequencer.sv
// Command-side initiator for the external 4-bit ALU. Accepts one command
// at a time, runs it through the ALU (or loads an immediate), writes the
// result back to the register file and returns a response.
module alu_4bit_sequencer
    import alu_pkg::*;
#(
    parameter  int NREGS = 4,
    localparam int IDX_W = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    // command channel
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_load,
    input  logic [2:0]       cmd_op,
    input  logic [IDX_W-1:0] cmd_src_a,
    input  logic [IDX_W-1:0] cmd_src_b,
    input  logic [IDX_W-1:0] cmd_dst,
    input  logic [ALU_W-1:0] cmd_imm,
    // ALU side
    output logic [ALU_W-1:0] alu_a,
    output logic [ALU_W-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [ALU_W-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    input  logic             alu_zero,
    // response channel
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [ALU_W-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_overflow,
    output logic             rsp_zero
);

    seq_state_e state_q, state_d;

    // Latched command fields; they steer the ALU during EXEC so the ALU
    // inputs do not depend on the (possibly changing) command bus.
    logic [2:0]       op_q,    op_d;
    logic [IDX_W-1:0] src_a_q, src_a_d;
    logic [IDX_W-1:0] src_b_q, src_b_d;
    logic [IDX_W-1:0] dst_q,   dst_d;

    alu_rsp_t rsp_q, rsp_d;

    logic             accept;
    logic             rf_we;
    logic [IDX_W-1:0] rf_waddr;
    logic [ALU_W-1:0] rf_wdata;
    logic [ALU_W-1:0] rf_rdata_a;
    logic [ALU_W-1:0] rf_rdata_b;

    assign accept = cmd_valid && (state_q == ST_IDLE);

    alu_seq_regfile #(
        .NREGS (NREGS),
        .IDX_W (IDX_W)
    ) u_rf (
        .clk       (clk),
        .rst       (rst),
        .we_i      (rf_we),
        .waddr_i   (rf_waddr),
        .wdata_i   (rf_wdata),
        .raddr_a_i (src_a_q),
        .raddr_b_i (src_b_q),
        .rdata_a_o (rf_rdata_a),
        .rdata_b_o (rf_rdata_b)
    );

    // FSM state register; reset aborts any in-flight command or response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: loads skip EXEC, ALU ops spend exactly one cycle there.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_valid) state_d = cmd_load ? ST_RESP : ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: handshakes, quiet-unless-EXEC ALU drive, write-back port.
    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
        alu_a     = '0;
        alu_b     = '0;
        alu_sel   = '0;
        rf_we     = 1'b0;
        rf_waddr  = dst_q;
        rf_wdata  = alu_result;
        case (state_q)
            ST_IDLE: begin
                // Immediate load writes straight from the command bus.
                rf_we    = cmd_valid && cmd_load;
                rf_waddr = cmd_dst;
                rf_wdata = cmd_imm;
            end
            ST_EXEC: begin
                alu_a   = rf_rdata_a;
                alu_b   = rf_rdata_b;
                alu_sel = op_q;
                // Operands were read combinationally this cycle, so writing
                // the same register at the closing edge is safe.
                rf_we   = 1'b1;
            end
            default: ;
        endcase
    end

    // Next values for the command latch and the response holding register.
    always_comb begin
        op_d    = op_q;
        src_a_d = src_a_q;
        src_b_d = src_b_q;
        dst_d   = dst_q;
        rsp_d   = rsp_q;
        if (accept) begin
            op_d    = cmd_op;
            src_a_d = cmd_src_a;
            src_b_d = cmd_src_b;
            dst_d   = cmd_dst;
            if (cmd_load) rsp_d = load_rsp(cmd_imm);
        end else if (state_q == ST_EXEC) begin
            // Flags are forwarded exactly as the ALU reports them.
            rsp_d.result   = alu_result;
            rsp_d.carry    = alu_carry;
            rsp_d.overflow = alu_overflow;
            rsp_d.zero     = alu_zero;
        end
    end

    // Command latch and response register; response stays stable in RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= '0;
            src_a_q <= '0;
            src_b_q <= '0;
            dst_q   <= '0;
            rsp_q   <= '0;
        end else begin
            op_q    <= op_d;
            src_a_q <= src_a_d;
            src_b_q <= src_b_d;
            dst_q   <= dst_d;
            rsp_q   <= rsp_d;
        end
    end

    assign rsp_result   = rsp_q.result;
    assign rsp_carry    = rsp_q.carry;
    assign rsp_overflow = rsp_q.overflow;
    assign rsp_zero     = rsp_q.zero;

endmodule

// File: tb/tb_alu_4bit_sequencer.sv
// Bench for alu_4bit_sequencer: directed scenarios, a randomized command
// stream against an arithmetic reference model, and reset-abort checks.
module tb_alu_4bit_sequencer;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_load;
    logic [2:0] cmd_op;
    logic [1:0] cmd_src_a, cmd_src_b, cmd_dst;
    logic [3:0] cmd_imm;
    logic [3:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_sel;
    logic       alu_carry, alu_overflow, alu_zero;
    logic       rsp_valid, rsp_ready;
    logic [3:0] rsp_result;
    logic       rsp_carry, rsp_overflow, rsp_zero;

    int tests = 0;
    int fails = 0;

    logic [3:0] rf_m [4];
    logic [3:0] last_res;
    logic       last_c, last_v, last_z;

    always #5 clk = ~clk;

    alu_4bit_sequencer #(.NREGS(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_load     (cmd_load),
        .cmd_op       (cmd_op),
        .cmd_src_a    (cmd_src_a),
        .cmd_src_b    (cmd_src_b),
        .cmd_dst      (cmd_dst),
        .cmd_imm      (cmd_imm),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_sel      (alu_sel),
        .alu_result   (alu_result),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow),
        .alu_zero     (alu_zero),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_carry    (rsp_carry),
        .rsp_overflow (rsp_overflow),
        .rsp_zero     (rsp_zero)
    );

    // The combinational 4-bit ALU the sequencer drives. SUB reports borrow
    // on CARRY; OVERFLOW uses the same-sign rule on every op, unmasked.
    always_comb begin
        alu_result = '0;
        alu_carry  = 1'b0;
        case (alu_sel)
            OP_ADD: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            OP_SUB: begin alu_result = alu_a - alu_b; alu_carry = (alu_a < alu_b); end
            OP_AND: alu_result = alu_a & alu_b;
            OP_OR:  alu_result = alu_a | alu_b;
            OP_XOR: alu_result = alu_a ^ alu_b;
            OP_GT:  alu_result = {3'b000, (alu_a > alu_b)};
            OP_SHL: begin alu_result = {alu_a[2:0], 1'b0}; alu_carry = alu_a[3]; end
            default: begin alu_result = {1'b0, alu_a[3:1]}; alu_carry = alu_a[0]; end
        endcase
        alu_overflow = (alu_a[3] ~^ alu_b[3]) & (alu_result[3] ^ alu_a[3]);
        alu_zero     = ~|alu_result;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sgn(input int v);
        return (v >= 8) ? v - 16 : v;
    endfunction

    // Reference ALU from plain integer arithmetic.
    task automatic ref_alu(input logic [2:0] op, input logic [3:0] a4, input logic [3:0] b4,
                           output logic [3:0] r, output logic c, output logic v, output logic z);
        int a, b, s;
        a = int'(a4);
        b = int'(b4);
        c = 1'b0;
        case (op)
            OP_ADD: begin s = a + b; c = (s > 15); s = s % 16; end
            OP_SUB: begin s = (a - b + 16) % 16; c = (a < b); end
            OP_AND: s = int'(a4 & b4);
            OP_OR:  s = int'(a4 | b4);
            OP_XOR: s = int'(a4 ^ b4);
            OP_GT:  s = (a > b) ? 1 : 0;
            OP_SHL: begin s = (a * 2) % 16; c = (a >= 8); end
            default: begin s = a / 2; c = (a % 2 == 1); end
        endcase
        r = 4'(s);
        v = ((sgn(a) < 0) == (sgn(b) < 0)) && ((sgn(s) < 0) != (sgn(a) < 0));
        z = (s == 0);
    endtask

    // Issue one command, check its latency, ALU drive, response and
    // backpressure behaviour, then retire it into the model.
    task automatic do_cmd(input bit ld, input logic [2:0] op, input logic [1:0] sa,
                          input logic [1:0] sb, input logic [1:0] d, input logic [3:0] imm,
                          input int hold);
        logic [3:0] er;
        logic       ec, ev, ez;
        int         lat;
        if (ld) begin
            er = imm; ec = 1'b0; ev = 1'b0; ez = (imm == 4'd0);
        end else begin
            ref_alu(op, rf_m[sa], rf_m[sb], er, ec, ev, ez);
        end
        chk("idle_cmd_ready", 16'(cmd_ready), 16'd1);
        chk("idle_rsp_valid", 16'(rsp_valid), 16'd0);
        chk("idle_alu_quiet", {5'd0, alu_sel, alu_a, alu_b}, 16'd0);
        cmd_valid = 1'b1; cmd_load = ld; cmd_op = op;
        cmd_src_a = sa; cmd_src_b = sb; cmd_dst = d; cmd_imm = imm;
        @(posedge clk); #1;
        // Keep a scrambled command on the bus; it must be ignored while busy.
        cmd_load = 1'($urandom); cmd_op = 3'($urandom); cmd_src_a = 2'($urandom);
        cmd_src_b = 2'($urandom); cmd_dst = 2'($urandom); cmd_imm = 4'($urandom);
        chk("busy_cmd_ready", 16'(cmd_ready), 16'd0);
        if (!ld) begin
            chk("exec_alu_a", 16'(alu_a), 16'(rf_m[sa]));
            chk("exec_alu_b", 16'(alu_b), 16'(rf_m[sb]));
            chk("exec_alu_sel", 16'(alu_sel), 16'(op));
        end
        lat = 1;
        while (!rsp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("rsp_latency", 16'(lat), ld ? 16'd1 : 16'd2);
        chk("rsp_result", 16'(rsp_result), 16'(er));
        chk("rsp_flags", {13'd0, rsp_carry, rsp_overflow, rsp_zero}, {13'd0, ec, ev, ez});
        last_res = rsp_result; last_c = rsp_carry; last_v = rsp_overflow; last_z = rsp_zero;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("bp_rsp_valid", 16'(rsp_valid), 16'd1);
            chk("bp_rsp_result", 16'(rsp_result), 16'(er));
            chk("bp_cmd_ready", 16'(cmd_ready), 16'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("post_hs_rsp_valid", 16'(rsp_valid), 16'd0);
        rf_m[d] = er;
    endtask

    // Read a register through OR rX,rX -> rX (leaves it unchanged).
    task automatic rd_reg(input logic [1:0] i, input logic [3:0] exp);
        do_cmd(1'b0, OP_OR, i, i, i, 4'd0, 0);
        chk("reg_readback", 16'(last_res), 16'(exp));
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = '0;
        cmd_src_a = '0; cmd_src_b = '0; cmd_dst = '0; cmd_imm = '0; rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) rf_m[i] = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_cmd_ready", 16'(cmd_ready), 16'd1);
        chk("reset_rsp_valid", 16'(rsp_valid), 16'd0);
        chk("reset_rsp", {11'd0, rsp_result, rsp_carry, rsp_overflow, rsp_zero}, 16'd0);
        chk("reset_alu", {5'd0, alu_sel, alu_a, alu_b}, 16'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) rd_reg(2'(i), 4'd0);

        // Loads
        do_cmd(1'b1, OP_ADD, 2'd0, 2'd0, 2'd0, 4'd7, 0);
        chk("load7", {11'd0, last_res, last_c, last_v, last_z}, {11'd0, 4'd7, 3'b000});
        do_cmd(1'b1, OP_ADD, 2'd0, 2'd0, 2'd1, 4'd9, 0);
        chk("load9", {11'd0, last_res, last_c, last_v, last_z}, {11'd0, 4'd9, 3'b000});

        // ADD wraps to zero with carry
        do_cmd(1'b0, OP_ADD, 2'd0, 2'd1, 2'd2, 4'd0, 0);
        chk("add_7_9", {11'd0, last_res, last_c, last_v, last_z}, {11'd0, 4'd0, 3'b101});
        rd_reg(2'd2, 4'd0);

        // SUB: borrow on carry, overflow passed through
        do_cmd(1'b1, OP_ADD, 2'd0, 2'd0, 2'd0, 4'd3, 0);
        do_cmd(1'b1, OP_ADD, 2'd0, 2'd0, 2'd1, 4'd5, 0);
        do_cmd(1'b0, OP_SUB, 2'd0, 2'd1, 2'd3, 4'd0, 1);
        chk("sub_3_5", {11'd0, last_res, last_c, last_v, last_z}, {11'd0, 4'b1110, 3'b110});

        // GT under 5 cycles of backpressure
        do_cmd(1'b1, OP_ADD, 2'd0, 2'd0, 2'd0, 4'd9, 0);
        do_cmd(1'b1, OP_ADD, 2'd0, 2'd0, 2'd1, 4'd7, 0);
        do_cmd(1'b0, OP_GT, 2'd0, 2'd1, 2'd2, 4'd0, 5);
        chk("gt_9_7", 16'(last_res), 16'd1);

        // In-place ops
        do_cmd(1'b1, OP_ADD, 2'd0, 2'd0, 2'd1, 4'd9, 0);
        do_cmd(1'b0, OP_XOR, 2'd1, 2'd1, 2'd1, 4'd0, 0);
        chk("xor_self", {15'd0, last_z}, 16'd1);
        chk("xor_self_res", 16'(last_res), 16'd0);
        rd_reg(2'd1, 4'd0);
        do_cmd(1'b1, OP_ADD, 2'd0, 2'd0, 2'd0, 4'b1001, 0);
        do_cmd(1'b0, OP_SHL, 2'd0, 2'd0, 2'd0, 4'd0, 2);
        chk("shl_1001", 16'(last_res), 16'b0010);

        // Randomized command stream against the model
        for (int n = 0; n < 40; n++) begin
            do_cmd(($urandom_range(0, 3) == 0), 3'($urandom), 2'($urandom), 2'($urandom),
                   2'($urandom), 4'($urandom), $urandom_range(0, 2));
        end
        for (int i = 0; i < 4; i++) rd_reg(2'(i), rf_m[i]);

        // Reset while in EXEC aborts the command
        do_cmd(1'b1, OP_ADD, 2'd0, 2'd0, 2'd0, 4'd6, 0);
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = OP_ADD;
        cmd_src_a = 2'd0; cmd_src_b = 2'd0; cmd_dst = 2'd3;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("abort_in_exec_sel", 16'(alu_a), 16'd6);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) rf_m[i] = 4'd0;
        chk("abort_rsp_valid", 16'(rsp_valid), 16'd0);
        chk("abort_cmd_ready", 16'(cmd_ready), 16'd1);
        chk("abort_rsp", {11'd0, rsp_result, rsp_carry, rsp_overflow, rsp_zero}, 16'd0);
        chk("abort_alu", {5'd0, alu_sel, alu_a, alu_b}, 16'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("abort_no_rsp", 16'(rsp_valid), 16'd0);
        end
        for (int i = 0; i < 4; i++) rd_reg(2'(i), 4'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_4bit_sequencer.md
Name: alu_4bit_sequencer

Overview:
- Command-side initiator for the 4-bit ALU datapath.
- Accepts register-level commands over a valid/ready interface and holds a small 4-bit register file.
- Drives the ALU's A/B/SEL inputs, captures RESULT/CARRY/OVERFLOW/ZERO, writes RESULT back to the register file, and returns a response over a second valid/ready interface.
- The ALU itself is a separate combinational instance wired to the alu_* ports.

Parameters:
- NREGS, 4, number of 4-bit registers; power of two, minimum 2.
- IDX_W, $clog2(NREGS), register index width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_load  input  1  1 = load immediate into cmd_dst; 0 = ALU operation.
- cmd_op  input  3  ALU select code, passed to alu_sel; ignored when cmd_load=1.
- cmd_src_a  input  IDX_W  source register for ALU A.
- cmd_src_b  input  IDX_W  source register for ALU B.
- cmd_dst  input  IDX_W  destination register.
- cmd_imm  input  4  immediate for loads.
- alu_a  output  4  to ALU A.
- alu_b  output  4  to ALU B.
- alu_sel  output  3  to ALU SEL.
- alu_result  input  4  from ALU RESULT.
- alu_carry  input  1  from ALU CARRY.
- alu_overflow  input  1  from ALU OVERFLOW.
- alu_zero  input  1  from ALU ZERO.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_result  output  4  value written to cmd_dst.
- rsp_carry  output  1  captured carry.
- rsp_overflow  output  1  captured overflow.
- rsp_zero  output  1  captured zero.

Behaviour:
- Reset values: state=IDLE; all registers=0; cmd_ready=1; rsp_valid=0; rsp_result/rsp_carry/rsp_overflow/rsp_zero=0; alu_a/alu_b/alu_sel=0.
- Reset mid-operation aborts any in-flight command and discards any pending response.
- FSM states: IDLE, EXEC, RESP.
- IDLE: cmd_ready=1. On cmd_valid, latch cmd_load, op, src_a, src_b, dst and imm.
  - cmd_load=0: go to EXEC.
  - cmd_load=1: write imm to rf[dst] at this edge, load rsp_result=imm, rsp_zero=(imm==0), rsp_carry=0, rsp_overflow=0, go to RESP.
- EXEC (exactly 1 cycle): alu_a=rf[src_a], alu_b=rf[src_b], alu_sel=op, all driven from the latched command registers, so outputs are stable for the whole cycle. At the end of the cycle:
  - rf[dst] <= alu_result;
  - rsp_* <= alu_* inputs;
  - go to RESP.
- RESP: rsp_valid=1; rsp_* held stable until rsp_valid&rsp_ready. On handshake, go to IDLE.
- cmd_ready=0 in EXEC and RESP. Only one command is outstanding, so there are no read-after-write hazards.
- Latency:
  - ALU op: accept at cycle 0, rsp_valid at cycle 2. Throughput is 1 op per 3 cycles with rsp_ready tied high.
  - Load: rsp_valid at cycle 1.
- alu_a/alu_b/alu_sel are 0 outside EXEC, which keeps the ALU inputs quiet.
- src_a==src_b is legal; both ports read the same register.
- dst equal to a source is legal. The register file write occurs at the end of EXEC, after operands were sampled.
- Flags are passed through unmodified. The sequencer does not reinterpret CARRY as borrow, and it does not mask OVERFLOW for logic ops.
- Register file: synchronous write, combinational read, single write port (one write per cycle max).
- Out-of-range indices cannot occur because NREGS is a power of two.
- No cmd_valid during EXEC/RESP has any effect; the command must stay asserted until cmd_ready.

Decomposition:
- Shared package alu_pkg holds:
  - ALU opcode constants: OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_XOR=4, OP_GT=5, OP_SHL=6, OP_SHR=7;
  - ALU data width constant ALU_W=4;
  - FSM state encoding (IDLE/EXEC/RESP).
- One sub-module: alu_seq_regfile (NREGS x 4, two async read ports, one sync write port, sync reset to 0).
- The bench instantiates alu_4bit_sequencer plus the existing ALU.

Test Plan:
- Reset then loads: load R0=7, R1=9 -> each response rsp_result=imm, zero=0, carry=0, overflow=0, rsp_valid one cycle after accept.
- ADD R2=R0+R1 with R0=7, R1=9 -> rsp_result=0, carry=1, zero=1, overflow=0; R2 reads 0 afterwards; rsp_valid 2 cycles after accept.
- SUB R3=R0-R1 with R0=3, R1=5 -> rsp_result=4'b1110, carry=1, overflow=1, zero=0. This confirms ALU flags are passed through unchanged.
- Backpressure: GT R0,R1 with R0=9, R1=7 while rsp_ready=0 for 5 cycles -> rsp_result=1 held stable, cmd_ready=0 throughout, single handshake when rsp_ready=1.
- In-place op: XOR R1=R1^R1 with R1=9 -> rsp_result=0, zero=1; R1=0 afterwards; SHL R0 with R0=4'b1001 -> rsp_result=4'b0010.
- Reset asserted during EXEC -> next cycle rsp_valid=0, cmd_ready=1, all registers read 0; no response is ever issued for the aborted command.
